// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage hazard controller for a 4-stage
// (ID, EX, MEM, WB) delayed-branch pipeline.
//
// A 3-entry shadow scoreboard mirrors the EX, MEM and WB stages. From it the
// block derives the decode stall, the ID/EX bubble, and the forwarding select
// for the branch zero-compare operand (aluselectA).
//
// Optional feature macro: ID_HAZARD_STALL_COUNT_EN
//   defined   -> stall_cycles counts clock edges with stall=1 (wraps at 2^32)
//   undefined -> counter not built, stall_cycles tied to 0
module id_hazard_ctrl #(
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_branch,
  input  logic [REGW-1:0] id_destreg,
  input  logic            id_regwrite,
  input  logic            id_mem2reg,
  output logic            stall,
  output logic            ex_bubble,
  output logic [1:0]      aluselectA,
  output logic [31:0]     stall_cycles
);

  typedef struct packed {
    logic            v;
    logic [REGW-1:0] dest;
    logic            wr;
    logic            ld;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '{v: 1'b0, dest: {REGW{1'b0}}, wr: 1'b0, ld: 1'b0};

  entry_t ex_r;
  entry_t mem_r;
  entry_t wb_r;

  logic       br_stall_s;
  logic       lu_stall_s;
  logic       stall_s;
  logic [1:0] br_sel_s;

  // True when the entry will write register r; r0 never counts as a writer.
  function automatic logic is_writer(input entry_t e, input logic [REGW-1:0] r);
    return e.v & e.wr & (e.dest == r) & (r != {REGW{1'b0}});
  endfunction

  // Branch operand resolution: nearest stage wins, loads not yet in WB stall.
  always_comb begin
    br_stall_s = 1'b0;
    br_sel_s   = 2'd0;
    if (id_valid && id_branch && id_uses_rs1) begin
      if (is_writer(ex_r, id_rs1)) begin
        br_stall_s = 1'b1;
      end else if (is_writer(mem_r, id_rs1) && mem_r.ld) begin
        br_stall_s = 1'b1;
      end else if (is_writer(mem_r, id_rs1)) begin
        br_sel_s = 2'd1;
      end else if (is_writer(wb_r, id_rs1)) begin
        br_sel_s = 2'd2;
      end else begin
        br_sel_s = 2'd0;
      end
    end else begin
      br_stall_s = 1'b0;
      br_sel_s   = 2'd0;
    end
  end

  // Load-use detection against the load currently in EX (rs1==rs2 is one hazard).
  always_comb begin
    lu_stall_s = 1'b0;
    if (id_valid && ex_r.ld &&
        ((id_uses_rs1 && is_writer(ex_r, id_rs1)) ||
         (id_uses_rs2 && is_writer(ex_r, id_rs2)))) begin
      lu_stall_s = 1'b1;
    end else begin
      lu_stall_s = 1'b0;
    end
  end

  // Combine hazards; the forward select is forced to 0 while stalling.
  always_comb begin
    stall_s    = br_stall_s | lu_stall_s;
    stall      = stall_s;
    ex_bubble  = stall_s;
    aluselectA = 2'd0;
    if (stall_s) begin
      aluselectA = 2'd0;
    end else begin
      aluselectA = br_sel_s;
    end
  end

  // Shadow scoreboard shift: a stalled ID instruction enters EX as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= EMPTY_ENTRY;
      mem_r <= EMPTY_ENTRY;
      wb_r  <= EMPTY_ENTRY;
    end else begin
      wb_r    <= mem_r;
      mem_r   <= ex_r;
      ex_r.v    <= id_valid & ~stall_s;
      ex_r.dest <= id_destreg;
      ex_r.wr   <= id_regwrite;
      ex_r.ld   <= id_mem2reg;
    end
  end

`ifdef ID_HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cnt_r;

  // Free-running stall-cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Hazard controller for the decode stage of the 4-stage delayed-branch pipeline (ID, EX, MEM, WB). It tracks in-flight register writers in a 3-entry shadow scoreboard that mirrors EX, MEM and WB. From that scoreboard it drives the decode register's `stall`, the bubble into ID/EX, and the 2-bit `aluselectA` forwarding select of the branch zero-compare operand. It sits beside the decode block and is the only source of those three controls.

## Interface
Parameters:
- `REGW`, 5: register index width.

Ports (all in the `clk` domain):
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction; 0 for bubble/reset NOP.
- `id_rs1`  in  REGW  source 1 index of the ID instruction.
- `id_rs2`  in  REGW  source 2 index of the ID instruction.
- `id_uses_rs1`  in  1  ID instruction reads rs1.
- `id_uses_rs2`  in  1  ID instruction reads rs2.
- `id_branch`  in  1  conditional branch; rs1 is compared to zero in ID.
- `id_destreg`  in  REGW  destination index (post regdst mux).
- `id_regwrite`  in  1  ID instruction writes `id_destreg`.
- `id_mem2reg`  in  1  ID instruction is a load.
- `stall`  out  1  hold the decode register and PC; 0 at reset.
- `ex_bubble`  out  1  load a NOP into ID/EX this cycle; equals `stall`; 0 at reset.
- `aluselectA`  out  2  0 regfile, 1 `priorALUresult` (MEM-stage ALU value), 2 `ALUwriteback` (WB value), 3 never driven; 0 at reset.
- `stall_cycles`  out  32  stall-cycle count (see Configuration); 0 at reset.

## Operation
Scoreboard:
- Entries EX, MEM and WB each hold {v, dest, wr, ld}.
- A "writer of r" is an entry with v=1, wr=1, dest=r and r≠0. Register 0 never creates a hazard or a forward.

Branch operand (id_valid=1, id_branch=1, id_uses_rs1=1). Check in order; the first match wins:
- EX is a writer of rs1 → `stall`=1. Covers both ALU ops and loads.
- MEM is a writer of rs1 with ld=1 → `stall`=1.
- MEM is a writer of rs1 with ld=0 → `aluselectA`=1.
- WB is a writer of rs1 → `aluselectA`=2.
- Otherwise → `aluselectA`=0.

Load-use (id_valid=1):
- EX is a writer with ld=1 whose dest matches a used rs1 or rs2 → `stall`=1.

General rules:
- `stall` is the OR of the branch and load-use conditions.
- While `stall`=1, `aluselectA` is don't-care but is driven 0.
- When id_valid=0, `stall`=0 and `aluselectA`=0.

Update at each rising `clk`:
- WB←MEM.
- MEM←EX.
- EX←{id_valid & ~stall, id_destreg, id_regwrite, id_mem2reg}. During a stall a bubble (v=0) enters EX.

Resulting stall lengths:
- Branch after an ALU producer in EX: 1 cycle.
- Branch after a load in EX: 2 cycles.
- ALU consumer after a load in EX: 1 cycle.

## Timing
- `stall`, `ex_bubble` and `aluselectA` are combinational from the ID inputs and the scoreboard, and are valid before the same `clk` edge they act on.
- Scoreboard latency is 1 cycle per stage. An ID writer is visible in EX one edge after it leaves ID.
- Stalls terminate without any counter, because bubbles advance the scoreboard. No stall can exceed 2 consecutive cycles.
- The ID inputs must stay stable during a stall. The decode register guarantees this because it is held.
- Asserting `rst_n`=0 asynchronously clears all entries (v=0) and `stall_cycles`, and forces all outputs to 0. This holds mid-stall too: the first cycle after release never stalls.
- Multiple writers of the same register: the nearest stage wins, i.e. EX over MEM over WB.
- rs1=rs2 with both used counts as one hazard, not a double stall.

## Configuration
- `ID_HAZARD_STALL_COUNT_EN`:
  - Defined: `stall_cycles` increments by 1 on every `clk` edge where `stall`=1, and wraps from 0xFFFFFFFF to 0.
  - Undefined: the counter is not built and `stall_cycles` is tied to 0.

## Test plan
- Reset mid-stall: load r5 in EX, branch on r5 in ID, `stall`=1; pulse `rst_n`=0 → all outputs 0 immediately; after release with the same ID inputs, `stall`=0.
- ALU `add r3` then branch on r3 → `stall`=1 for 1 cycle, then `aluselectA`=1; `stall_cycles`=1 with the macro defined.
- Load to r4 then branch on r4 → `stall`=1 for 2 cycles, then `aluselectA`=2; `stall_cycles`=2.
- Load to r7 then `add` reading rs2=r7 (non-branch) → `stall`=1 for exactly 1 cycle with `ex_bubble`=1; EX entry v=0 on the next cycle.
- Writes to r0 in EX and MEM, then branch on r0 → `stall`=0, `aluselectA`=0.
- MEM writes r9 (ALU) and WB writes r9, branch on r9 → `aluselectA`=1 (MEM priority); with only WB writing r9 → `aluselectA`=2.
